// File: rtl/out_display_pkg.sv
// out_display_pkg: shared types, segment codes and the double-dabble nibble adjust
package out_display_pkg;

    typedef enum logic [1:0] {IDLE, CONVERT, COMMIT} state_t;

    typedef logic [1:0] digit_idx_t;

    localparam digit_idx_t DIG_UNITS    = 2'd0;
    localparam digit_idx_t DIG_TENS     = 2'd1;
    localparam digit_idx_t DIG_HUNDREDS = 2'd2;
    localparam digit_idx_t DIG_SIGN     = 2'd3;

    localparam logic [6:0] SEG_BLANK = 7'b0000000;
    localparam logic [6:0] SEG_MINUS = 7'b1000000;

    localparam logic [9:0][6:0] SEG_DIGIT = {
        7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [3:0] dd_adjust(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

endpackage

// File: rtl/out_display_seg7_decode.sv
// seg7_decode: BCD digit plus blank/minus controls to active-high {g,f,e,d,c,b,a}
import out_display_pkg::*;

module seg7_decode (
    input  logic [3:0] bcd_i,
    input  logic       blank_i,
    input  logic       minus_i,
    output logic [6:0] seg_o
);

    assign seg_o = minus_i ? SEG_MINUS :
                   (blank_i || bcd_i > 4'd9) ? SEG_BLANK : SEG_DIGIT[bcd_i];

endmodule

// File: rtl/out_display.sv
// out_display: binary-to-BCD conversion of the CPU output register and a 4-digit multiplexed display
import out_display_pkg::*;

module out_display #(
    parameter int unsigned REFRESH_DIV = 1024,
    parameter bit          SIGNED_MODE = 1'b0,
    parameter bit          BLANK_LZ    = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        out_load,
    input  logic [7:0]  out_value,
    output logic [6:0]  seg,
    output logic [3:0]  digit_en,
    output logic [11:0] bcd,
    output logic        busy
);

    state_t      state_q;
    logic [19:0] sh_q;
    logic [2:0]  step_q;
    logic        sign_cap_q;
    logic        sign_q;
    logic [11:0] bcd_q;
    logic        busy_q;
    logic        pend_v_q;
    logic [7:0]  pend_q;
    logic [15:0] ref_q;
    digit_idx_t  dig_q;
    logic [3:0]  den_q;
    logic [6:0]  seg_q;

    logic [7:0]  src;
    logic        neg;
    logic [7:0]  mag;
    logic        start;
    logic [19:0] adj;
    logic        wrap;
    digit_idx_t  dig_d;
    logic [3:0]  nib;
    logic        blank;
    logic        minus;
    logic [6:0]  seg_d;

    // a load seen during COMMIT is newer than anything pending, so it wins
    always_comb begin
        src   = (state_q == COMMIT && !out_load) ? pend_q : out_value;
        neg   = SIGNED_MODE && src[7];
        mag   = neg ? -src : src;
        start = (state_q == IDLE && out_load) || (state_q == COMMIT && (out_load || pend_v_q));
        adj   = {dd_adjust(sh_q[19:16]), dd_adjust(sh_q[15:12]), dd_adjust(sh_q[11:8]), sh_q[7:0]};
        wrap  = ref_q == 16'(REFRESH_DIV - 1);
        dig_d = wrap ? digit_idx_t'(dig_q + 2'd1) : dig_q;
        nib   = (dig_d == DIG_UNITS) ? bcd_q[3:0] : (dig_d == DIG_TENS) ? bcd_q[7:4] : bcd_q[11:8];
        minus = (dig_d == DIG_SIGN) && sign_q;
        blank = (dig_d == DIG_SIGN)     ? !sign_q :
                (dig_d == DIG_HUNDREDS) ? BLANK_LZ && bcd_q[11:8] == 4'd0 :
                (dig_d == DIG_TENS)     ? BLANK_LZ && bcd_q[11:4] == 8'd0 : 1'b0;
    end

    seg7_decode u_dec (
        .bcd_i   (nib),
        .blank_i (blank),
        .minus_i (minus),
        .seg_o   (seg_d)
    );

    // conversion FSM, pending slot, committed result and display scan
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            sh_q       <= '0;
            step_q     <= '0;
            sign_cap_q <= 1'b0;
            sign_q     <= 1'b0;
            bcd_q      <= '0;
            busy_q     <= 1'b0;
            pend_v_q   <= 1'b0;
            pend_q     <= '0;
            ref_q      <= '0;
            dig_q      <= DIG_UNITS;
            den_q      <= 4'b0001;
            seg_q      <= SEG_BLANK;
        end else begin
            ref_q <= wrap ? 16'd0 : ref_q + 16'd1;
            dig_q <= dig_d;
            den_q <= 4'b0001 << dig_d;
            seg_q <= seg_d;
            if (start) begin
                state_q    <= CONVERT;
                sh_q       <= {12'd0, mag};
                step_q     <= '0;
                sign_cap_q <= neg;
                busy_q     <= 1'b1;
            end else if (state_q == CONVERT) begin
                sh_q   <= adj << 1;
                step_q <= step_q + 3'd1;
                if (step_q == 3'd7)
                    state_q <= COMMIT;
            end else if (state_q == COMMIT) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
            end
            if (state_q == COMMIT) begin
                bcd_q    <= sh_q[19:8];
                sign_q   <= sign_cap_q;
                pend_v_q <= 1'b0;
            end else if (state_q != IDLE && out_load) begin
                pend_v_q <= 1'b1;
                pend_q   <= out_value;
            end
        end
    end

    assign seg      = seg_q;
    assign digit_en = den_q;
    assign bcd      = bcd_q;
    assign busy     = busy_q;

endmodule

// File: doc/out_display.md
OUT_DISPLAY -- requirements
Module: out_display

Interface
REQ-001 Parameter REFRESH_DIV, default 1024: clk cycles each digit is driven before the scan advances; legal range 2..65535.
REQ-002 Parameter SIGNED_MODE, default 0: 1 = out_value is two's complement; 0 = out_value is unsigned.
REQ-003 Parameter BLANK_LZ, default 1: 1 = leading zeros blanked; 0 = all digits shown.
REQ-004 Clock and reset: one clock; reset is synchronous and active-low.
REQ-005 clk  input  1  system clock; all state changes on its rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 out_load  input  1  one-cycle strobe from the CPU output register: out_value is valid this cycle.
REQ-008 out_value  input  8  value written to the CPU output register.
REQ-009 seg  output  7  segments {g,f,e,d,c,b,a}, active-high.
REQ-010 digit_en  output  4  one-hot digit select, active-high; bit 3 = sign digit, bits 2..0 = hundreds, tens, units.
REQ-011 bcd  output  12  last completed conversion as {hundreds, tens, units}.
REQ-012 busy  output  1  high while a conversion is in progress.

Function
REQ-013 When out_load is high and busy is low, the block captures out_value and enters CONVERT on the next edge.
- SIGNED_MODE=1 and out_value[7]=1: convert magnitude = -out_value as 8-bit unsigned (8'h80 gives 128); sign flag = 1.
- Otherwise: convert out_value unchanged; sign flag = 0.
REQ-014 State machine IDLE -> CONVERT -> COMMIT -> IDLE.
- CONVERT runs a sequential double-dabble: exactly 8 cycles, one shift per cycle, add-3 applied to each BCD nibble >= 5 before the shift.
- COMMIT lasts 1 cycle.
REQ-015 bcd and the sign flag update atomically in COMMIT. Latency from the out_load edge to the new bcd is 10 cycles. busy is high from the cycle after capture through COMMIT.
REQ-016 An out_load arriving while busy=1 is stored in a one-deep pending register; a later load overwrites the pending value (last value wins).
REQ-017 A pending value starts converting in the cycle after COMMIT, with no intervening IDLE cycle and busy held high.
REQ-018 out_load in the same cycle as COMMIT is treated as pending; it is never dropped.
REQ-019 The display always shows the last committed bcd; partial conversion results never reach seg.
REQ-020 Refresh counter counts 0..REFRESH_DIV-1 and wraps. On wrap, digit_en rotates 0001 -> 0010 -> 0100 -> 1000 -> 0001.
REQ-021 seg for the selected digit:
- Digits 0..9 use standard 7-segment codes.
- Sign digit shows 7'b1000000 ('-', segment g only) when the sign flag is 1; otherwise blank (7'b0).
- BLANK_LZ=1: hundreds is blank if 0; tens is blank if both hundreds and tens are 0; units is never blanked.
REQ-022 seg and digit_en are registered and change on the same edge; there is no glitch between digits.

Reset
REQ-023 While rst_n=0 at an edge: seg=0, digit_en=4'b0001, bcd=0, busy=0, sign flag=0, refresh counter=0, pending cleared, state=IDLE.
REQ-024 Reset during CONVERT aborts the conversion; bcd stays 0 until a new load completes.

Structure
REQ-025 Shared package out_display_pkg holds:
- the state enum (IDLE, CONVERT, COMMIT);
- the 7-segment constants for 0..9, BLANK and MINUS;
- the digit-index type.
REQ-026 One sub-module, seg7_decode: combinational 4-bit BCD plus blank/minus controls to 7-bit seg. All sequential logic stays in out_display.

Verification
REQ-027 Unsigned range: SIGNED_MODE=0; load 8'd255 -> busy for 9 cycles, then bcd=12'h255 on cycle 10; load 8'd0 -> bcd=12'h000, with only the units digit lit showing '0' (7'b0111111).
REQ-028 Signed edge values: SIGNED_MODE=1.
- Load 8'hFF -> bcd=12'h001, sign digit 7'b1000000, hundreds and tens blank.
- Load 8'h80 -> bcd=12'h128, sign shown.
REQ-029 Back-to-back loads: load 8'd42, then 8'd7 two cycles later, then 8'd99 one cycle after that -> bcd reads 12'h042 and then 12'h099; 12'h007 never appears.
REQ-030 Collision and reset: out_load coincident with COMMIT -> the value is converted next.
- rst_n low for 1 cycle mid-CONVERT -> all outputs at reset values.
- A following load of 8'd5 -> bcd=12'h005.
REQ-031 Scan: REFRESH_DIV=4 -> digit_en advances every 4 cycles through 0001, 0010, 0100, 1000 and back to 0001 at cycle 16. seg always matches the selected digit on the same edge.
